reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised successor of the DAQ reset controller: gates NUM_DOMAINS peripheral resets
//  (ADC writer, synth, PDM, ...) from an internal/external trigger, each with its own
//  programmable release delay. Adds a real watchdog timeout, a sticky fault/ack handshake
//  and an exact-period alive heartbeat. Sits between the PS config/status registers and
//  the acquisition/generation datapath.
// PARAMETERS
//  NUM_DOMAINS      4         number of gated reset domains, 1..16
//  DELAY_W          16        width of each per-domain release-delay field (cycles)
//  WD_TIMEOUT       12500000  cycles without a watchdog edge before fault (>=2)
//  ALIVE_LOW        12500000  alive_signal low cycles per period (>=1)
//  ALIVE_HIGH       1250000   alive_signal high cycles per period (>=1)
// PORTS
//  clk               in   1                   system clock (125 MHz)
//  peripheral_reset  in   1                   synchronous, active-high reset
//  cfg_mode          in   1                   0 continuous, 1 trigger-gated
//  cfg_trig_sel      in   1                   0 internal, 1 external trigger
//  cfg_int_trig_en   in   1                   internal trigger level
//  cfg_watchdog_en   in   1                   enable watchdog timeout check
//  cfg_instant_en    in   1                   enable instant_reset_in as fault source
//  cfg_ack_clear     in   1                   single-cycle pulse: clear sticky fault
//  domain_mask       in   NUM_DOMAINS         1 = domain is trigger/fault gated
//  domain_delay      in   NUM_DOMAINS*DELAY_W release delay per domain, domain i at [i*DELAY_W +: DELAY_W]
//  ext_trigger       in   1                   asynchronous external trigger pin
//  watchdog_in       in   1                   asynchronous heartbeat; any edge = alive
//  instant_reset_in  in   1                   asynchronous instant-reset request, level
//  domain_aresetn    out  NUM_DOMAINS         active-low resets to peripherals
//  master_trigger    out  1                   internal trigger forwarded to slave boards
//  alive_signal      out  1                   heartbeat output
//  reset_ack         out  1                   high while fault latched
//  sts               out  32                  status word
// BEHAVIOUR
//  - Reset (peripheral_reset=1): all outputs 0, all counters 0, fault clear, domains in HOLD.
//  - ext_trigger, watchdog_in, instant_reset_in: 2-FF synchronisers; logic uses sync copies only.
//  - trig_q (registered): cfg_trig_sel ? ext_sync : cfg_int_trig_en. run = cfg_mode ? trig_q : 1.
//  - master_trigger = cfg_int_trig_en delayed 1 cycle.
//  - Watchdog: wd_cnt cleared on any ext edge of watchdog sync or when cfg_watchdog_en=0;
//    else increments, saturating; wd_cnt == WD_TIMEOUT-1 -> fault set next cycle, cause bit wd.
//  - Instant: cfg_instant_en & instant_sync -> fault set next cycle, cause bit inst.
//  - Fault sticky; reset_ack = fault. Cleared only by cfg_ack_clear when no cause is active
//    in that cycle; clear while cause active is ignored. Set and clear same cycle: set wins.
//  - Per-domain FSM, gate_i = mask_i ? (run & ~fault) : 1:
//    HOLD  (aresetn=0): gate_i -> DELAY, cnt=0 (if delay_i==0 -> RUN directly).
//    DELAY (aresetn=0): cnt++; cnt==delay_i-1 -> RUN; ~gate_i -> HOLD.
//    RUN   (aresetn=1): ~gate_i -> HOLD (aresetn low on the next edge).
//  - domain_aresetn is registered from FSM state. Latency ext_trigger rise -> aresetn rise:
//    4 + delay_i cycles; fall: 4 cycles. Fault set -> gated domains low 1 cycle later.
//  - domain_delay sampled on HOLD->DELAY entry; changes mid-DELAY take effect next sequence.
//  - Alive: counter 0..ALIVE_LOW+ALIVE_HIGH-1, wraps to 0; alive_signal=0 for first
//    ALIVE_LOW counts, 1 for ALIVE_HIGH counts (registered, period exact).
//  - sts: [0] run [1] fault [2] wd cause [3] inst cause [4] ext_sync [5] wd_sync
//    [6] inst_sync [7] trig_q [15:8] 0 [16+:NUM_DOMAINS] domain_aresetn, rest 0.
//    Cause bits sticky, cleared with fault.
// TESTING
//  1 mode=0, delays {0,3,10,1}: release reset -> aresetn[i] high at cycle 1+delay_i, stays high.
//  2 mode=1, sel=1, mask=all, delay0=5: ext_trigger rise -> aresetn[0] high 9 cycles later; fall -> low after 4.
//  3 WD_TIMEOUT=8, wd_en=1, no edges -> reset_ack=1, sts[2]=1, masked domains low; unmasked stay high.
//  4 inst_en=1, instant_reset held, ack_clear pulsed -> ignored; drop input, pulse -> ack=0, domains resequence.
//  5 ALIVE_LOW=3, ALIVE_HIGH=2 -> alive pattern 0,0,0,1,1 repeating exactly.
//  6 peripheral_reset asserted mid-DELAY and mid-fault -> next cycle all outputs 0, fault clear.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: gates NUM_DOMAINS peripheral resets from an internal or
// external trigger, releasing each domain after its own programmable delay.
// A watchdog timeout or an instant-reset request latches a sticky fault that
// pulls the gated domains back into reset until software acknowledges it.
// An alive heartbeat with an exact low/high period is produced alongside.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int DELAY_W     = 16,
    parameter int WD_TIMEOUT  = 12500000,
    parameter int ALIVE_LOW   = 12500000,
    parameter int ALIVE_HIGH  = 1250000
) (
    input  logic                           clk,
    input  logic                           peripheral_reset,
    input  logic                           cfg_mode,
    input  logic                           cfg_trig_sel,
    input  logic                           cfg_int_trig_en,
    input  logic                           cfg_watchdog_en,
    input  logic                           cfg_instant_en,
    input  logic                           cfg_ack_clear,
    input  logic [NUM_DOMAINS-1:0]         domain_mask,
    input  logic [NUM_DOMAINS*DELAY_W-1:0] domain_delay,
    input  logic                           ext_trigger,
    input  logic                           watchdog_in,
    input  logic                           instant_reset_in,
    output logic [NUM_DOMAINS-1:0]         domain_aresetn,
    output logic                           master_trigger,
    output logic                           alive_signal,
    output logic                           reset_ack,
    output logic [31:0]                    sts
);

    localparam int WD_W         = $clog2(WD_TIMEOUT);
    localparam int ALIVE_PERIOD = ALIVE_LOW + ALIVE_HIGH;
    localparam int AL_W         = $clog2(ALIVE_PERIOD);

    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WD_TIMEOUT - 1);
    localparam logic [AL_W-1:0] AL_LAST  = AL_W'(ALIVE_PERIOD - 1);
    localparam logic [AL_W-1:0] AL_LOW_C = AL_W'(ALIVE_LOW);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } dom_state_e;

    // bit 0: ext_trigger, bit 1: watchdog_in, bit 2: instant_reset_in
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    logic ext_sync_s;
    logic wd_sync_s;
    logic inst_sync_s;

    logic            trig_q,       trig_d;
    logic            run_q,        run_d;
    logic            mtrig_q;
    logic            wd_prev_q;
    logic [WD_W-1:0] wd_cnt_q,     wd_cnt_d;
    logic            fault_q,      fault_d;
    logic            wd_cause_q,   wd_cause_d;
    logic            inst_cause_q, inst_cause_d;
    logic [AL_W-1:0] alive_cnt_q,  alive_cnt_d;
    logic            alive_q,      alive_d;

    logic                   run_s;
    logic                   wd_edge_s;
    logic                   wd_hit_s;
    logic                   inst_hit_s;
    logic                   clear_s;
    logic [NUM_DOMAINS-1:0] gate_s;
    logic [NUM_DOMAINS-1:0] aresetn_s;
    logic [31:0]            sts_s;

    assign ext_sync_s  = sync_q[0];
    assign wd_sync_s   = sync_q[1];
    assign inst_sync_s = sync_q[2];

    // Two-flop synchronisers for the three asynchronous pins.
    always_ff @(posedge clk) begin
        if (peripheral_reset) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= {instant_reset_in, watchdog_in, ext_trigger};
            sync_q <= meta_q;
        end
    end

    // Trigger selection, watchdog, sticky fault, heartbeat and domain gates.
    always_comb begin
        trig_d     = cfg_trig_sel ? ext_sync_s : cfg_int_trig_en;
        run_d      = cfg_mode ? trig_d : 1'b1;
        run_s      = cfg_mode ? trig_q : 1'b1;

        wd_edge_s  = wd_sync_s ^ wd_prev_q;
        wd_hit_s   = cfg_watchdog_en & (wd_cnt_q == WD_LAST);
        if (!cfg_watchdog_en || wd_edge_s) begin
            wd_cnt_d = {WD_W{1'b0}};
        end else if (wd_cnt_q == WD_LAST) begin
            wd_cnt_d = wd_cnt_q;
        end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end

        inst_hit_s = cfg_instant_en & inst_sync_s;
        // An acknowledge only counts when no fault source is active.
        clear_s    = cfg_ack_clear & ~(wd_hit_s | inst_hit_s);

        if (wd_hit_s || inst_hit_s) begin
            fault_d = 1'b1;
        end else if (clear_s) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        if (wd_hit_s) begin
            wd_cause_d = 1'b1;
        end else if (clear_s) begin
            wd_cause_d = 1'b0;
        end else begin
            wd_cause_d = wd_cause_q;
        end

        if (inst_hit_s) begin
            inst_cause_d = 1'b1;
        end else if (clear_s) begin
            inst_cause_d = 1'b0;
        end else begin
            inst_cause_d = inst_cause_q;
        end

        if (alive_cnt_q == AL_LAST) begin
            alive_cnt_d = {AL_W{1'b0}};
        end else begin
            alive_cnt_d = alive_cnt_q + AL_W'(1);
        end
        alive_d = (alive_cnt_d >= AL_LOW_C);

        gate_s = {NUM_DOMAINS{1'b1}};
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (domain_mask[i]) begin
                gate_s[i] = run_s & ~fault_q;
            end else begin
                gate_s[i] = 1'b1;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (peripheral_reset) begin
            trig_q       <= 1'b0;
            run_q        <= 1'b0;
            mtrig_q      <= 1'b0;
            wd_prev_q    <= 1'b0;
            wd_cnt_q     <= {WD_W{1'b0}};
            fault_q      <= 1'b0;
            wd_cause_q   <= 1'b0;
            inst_cause_q <= 1'b0;
            alive_cnt_q  <= {AL_W{1'b0}};
            alive_q      <= 1'b0;
        end else begin
            trig_q       <= trig_d;
            run_q        <= run_d;
            mtrig_q      <= cfg_int_trig_en;
            wd_prev_q    <= wd_sync_s;
            wd_cnt_q     <= wd_cnt_d;
            fault_q      <= fault_d;
            wd_cause_q   <= wd_cause_d;
            inst_cause_q <= inst_cause_d;
            alive_cnt_q  <= alive_cnt_d;
            alive_q      <= alive_d;
        end
    end

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        dom_state_e         state_q;
        logic [DELAY_W-1:0] cnt_q;
        logic [DELAY_W-1:0] dly_q;
        logic               aresetn_q;
        logic [DELAY_W-1:0] dly_in_s;

        assign dly_in_s     = domain_delay[g*DELAY_W +: DELAY_W];
        assign aresetn_s[g] = aresetn_q;

        // Per-domain release sequencer; the delay is captured when leaving HOLD.
        always_ff @(posedge clk) begin
            if (peripheral_reset) begin
                state_q   <= ST_HOLD;
                cnt_q     <= {DELAY_W{1'b0}};
                dly_q     <= {DELAY_W{1'b0}};
                aresetn_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (gate_s[g]) begin
                            dly_q <= dly_in_s;
                            cnt_q <= {DELAY_W{1'b0}};
                            if (dly_in_s == {DELAY_W{1'b0}}) begin
                                state_q   <= ST_RUN;
                                aresetn_q <= 1'b1;
                            end else begin
                                state_q   <= ST_DELAY;
                                aresetn_q <= 1'b0;
                            end
                        end else begin
                            aresetn_q <= 1'b0;
                        end
                    end
                    ST_DELAY: begin
                        if (!gate_s[g]) begin
                            state_q   <= ST_HOLD;
                            aresetn_q <= 1'b0;
                        end else if (cnt_q == dly_q - DELAY_W'(1)) begin
                            state_q   <= ST_RUN;
                            aresetn_q <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + DELAY_W'(1);
                            aresetn_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!gate_s[g]) begin
                            state_q   <= ST_HOLD;
                            aresetn_q <= 1'b0;
                        end else begin
                            aresetn_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_HOLD;
                        aresetn_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Status word assembled purely from registered state.
    always_comb begin
        sts_s                    = 32'd0;
        sts_s[0]                 = run_q;
        sts_s[1]                 = fault_q;
        sts_s[2]                 = wd_cause_q;
        sts_s[3]                 = inst_cause_q;
        sts_s[4]                 = ext_sync_s;
        sts_s[5]                 = wd_sync_s;
        sts_s[6]                 = inst_sync_s;
        sts_s[7]                 = trig_q;
        sts_s[16 +: NUM_DOMAINS] = aresetn_s;
    end

    assign domain_aresetn = aresetn_s;
    assign master_trigger = mtrig_q;
    assign alive_signal   = alive_q;
    assign reset_ack      = fault_q;
    assign sts            = sts_s;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by a randomized
// phase, every cycle compared against a behavioural model of the sequencer.
module tb_reset_sequencer;

    localparam int ND   = 4;
    localparam int DW   = 8;
    localparam int WDT  = 8;
    localparam int AL_L = 3;
    localparam int AL_H = 2;

    logic          clk = 1'b0;
    logic          peripheral_reset = 1'b1;
    logic          cfg_mode = 1'b0;
    logic          cfg_trig_sel = 1'b0;
    logic          cfg_int_trig_en = 1'b0;
    logic          cfg_watchdog_en = 1'b0;
    logic          cfg_instant_en = 1'b0;
    logic          cfg_ack_clear = 1'b0;
    logic [ND-1:0] domain_mask = '0;
    logic [ND*DW-1:0] domain_delay = '0;
    logic          ext_trigger = 1'b0;
    logic          watchdog_in = 1'b0;
    logic          instant_reset_in = 1'b0;
    logic [ND-1:0] domain_aresetn;
    logic          master_trigger;
    logic          alive_signal;
    logic          reset_ack;
    logic [31:0]   sts;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(
        .NUM_DOMAINS(ND), .DELAY_W(DW), .WD_TIMEOUT(WDT),
        .ALIVE_LOW(AL_L), .ALIVE_HIGH(AL_H)
    ) dut (
        .clk(clk), .peripheral_reset(peripheral_reset),
        .cfg_mode(cfg_mode), .cfg_trig_sel(cfg_trig_sel),
        .cfg_int_trig_en(cfg_int_trig_en), .cfg_watchdog_en(cfg_watchdog_en),
        .cfg_instant_en(cfg_instant_en), .cfg_ack_clear(cfg_ack_clear),
        .domain_mask(domain_mask), .domain_delay(domain_delay),
        .ext_trigger(ext_trigger), .watchdog_in(watchdog_in),
        .instant_reset_in(instant_reset_in),
        .domain_aresetn(domain_aresetn), .master_trigger(master_trigger),
        .alive_signal(alive_signal), .reset_ack(reset_ack), .sts(sts)
    );

    always #5 clk = ~clk;

    // Reference model: pin histories, "edges since" counters and per-domain
    // streaks of consecutive enabled cycles instead of a state machine.
    logic e_h[2], w_h[3], i_h[2];   // [0] newest sample of the pin
    logic m_trig, m_run, m_mtrig, m_fault, m_wdc, m_inc, m_alive;
    int   m_quiet, m_phase;
    int   streak[ND], cap[ND];
    logic [ND-1:0] m_ares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_h = '{1'b0, 1'b0}; i_h = '{1'b0, 1'b0}; w_h = '{1'b0, 1'b0, 1'b0};
        m_trig = 1'b0; m_run = 1'b0; m_mtrig = 1'b0; m_fault = 1'b0;
        m_wdc = 1'b0; m_inc = 1'b0; m_alive = 1'b0;
        m_quiet = 0; m_phase = 0; m_ares = '0;
        for (int i = 0; i < ND; i++) begin
            streak[i] = 0;
            cap[i]    = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic run_now, gate, wd_hit, in_hit;
        if (peripheral_reset) begin
            model_reset();
        end else begin
            run_now = cfg_mode ? m_trig : 1'b1;
            for (int i = 0; i < ND; i++) begin
                gate = domain_mask[i] ? (run_now && !m_fault) : 1'b1;
                if (gate) begin
                    if (streak[i] == 0) cap[i] = int'(domain_delay[i*DW +: DW]);
                    if (streak[i] < 1000) streak[i]++;
                end else begin
                    streak[i] = 0;
                end
                m_ares[i] = (streak[i] > cap[i]);
            end
            wd_hit = cfg_watchdog_en && (m_quiet >= WDT - 1);
            in_hit = cfg_instant_en && i_h[1];
            if (!cfg_watchdog_en || (w_h[1] != w_h[2])) m_quiet = 0;
            else m_quiet++;
            if (wd_hit || in_hit) begin
                m_fault = 1'b1;
                m_wdc   = m_wdc | wd_hit;
                m_inc   = m_inc | in_hit;
            end else if (cfg_ack_clear) begin
                m_fault = 1'b0; m_wdc = 1'b0; m_inc = 1'b0;
            end
            m_trig  = cfg_trig_sel ? e_h[1] : cfg_int_trig_en;
            m_run   = cfg_mode ? m_trig : 1'b1;
            m_mtrig = cfg_int_trig_en;
            e_h[1] = e_h[0]; e_h[0] = ext_trigger;
            i_h[1] = i_h[0]; i_h[0] = instant_reset_in;
            w_h[2] = w_h[1]; w_h[1] = w_h[0]; w_h[0] = watchdog_in;
            m_phase = (m_phase + 1) % (AL_L + AL_H);
            m_alive = (m_phase >= AL_L);
        end
    endtask

    task automatic tick();
        logic [31:0] exp_sts;
        model_step();
        @(posedge clk);
        #1;
        exp_sts = 32'd0;
        exp_sts[16 +: ND] = m_ares;
        exp_sts[7:0] = {m_trig, i_h[1], w_h[1], e_h[1], m_inc, m_wdc, m_fault, m_run};
        chk("aresetn", 32'(domain_aresetn), 32'(m_ares));
        chk("reset_ack", 32'(reset_ack), 32'(m_fault));
        chk("alive", 32'(alive_signal), 32'(m_alive));
        chk("master_trigger", 32'(master_trigger), 32'(m_mtrig));
        chk("sts", sts, exp_sts);
    endtask

    task automatic do_reset(input int n);
        peripheral_reset = 1'b1;
        repeat (n) tick();
        peripheral_reset = 1'b0;
    endtask

    task automatic pulse_ack();
        cfg_ack_clear = 1'b1;
        tick();
        cfg_ack_clear = 1'b0;
    endtask

    initial begin
        int n;
        logic [4:0] pat;
        model_reset();

        // Reset state: everything low.
        do_reset(2);
        chk("reset_outputs", {domain_aresetn, master_trigger, alive_signal, reset_ack}, 32'd0);
        chk("reset_sts", sts, 32'd0);

        // 1: continuous mode, staggered release.
        domain_delay = {8'd1, 8'd10, 8'd3, 8'd0};
        peripheral_reset = 1'b1;
        tick();
        peripheral_reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t1_release", 32'(domain_aresetn),
                {28'd0, (k >= 2), (k >= 11), (k >= 4), (k >= 1)});
        end

        // 2: external trigger gating of domain 0 with delay 5.
        cfg_mode = 1'b1; cfg_trig_sel = 1'b1; domain_mask = 4'hF;
        domain_delay[7:0] = 8'd5;
        repeat (6) tick();
        chk("t2_idle", 32'(domain_aresetn), 32'd0);
        ext_trigger = 1'b1;
        n = 0;
        while (!domain_aresetn[0] && n < 30) begin tick(); n++; end
        chk("t2_rise_latency", 32'(n), 32'd9);
        ext_trigger = 1'b0;
        n = 0;
        while (domain_aresetn[0] && n < 30) begin tick(); n++; end
        chk("t2_fall_latency", 32'(n), 32'd4);

        // 3: watchdog timeout with no edges.
        cfg_mode = 1'b0; domain_mask = 4'b0101; domain_delay = '0;
        cfg_watchdog_en = 1'b1; watchdog_in = 1'b0;
        do_reset(1);
        n = 0;
        while (!reset_ack && n < 30) begin tick(); n++; end
        chk("t3_wd_latency", 32'(n), 32'd8);
        repeat (3) tick();
        chk("t3_ack", 32'(reset_ack), 32'd1);
        chk("t3_wd_cause", 32'(sts[2]), 32'd1);
        chk("t3_domains", 32'(domain_aresetn), 32'b1010);
        pulse_ack();
        chk("t3_clear_ignored", 32'(reset_ack), 32'd1);
        cfg_watchdog_en = 1'b0;
        tick();
        pulse_ack();
        chk("t3_clear", 32'(reset_ack), 32'd0);
        repeat (3) tick();

        // 4: instant reset, acknowledge while held then after release.
        domain_mask = 4'hF; domain_delay = {8'd3, 8'd1, 8'd0, 8'd2};
        cfg_instant_en = 1'b1; instant_reset_in = 1'b1;
        repeat (5) tick();
        chk("t4_ack", 32'(reset_ack), 32'd1);
        chk("t4_inst_cause", 32'(sts[3]), 32'd1);
        chk("t4_domains_low", 32'(domain_aresetn), 32'd0);
        pulse_ack();
        chk("t4_clear_ignored", 32'(reset_ack), 32'd1);
        instant_reset_in = 1'b0;
        repeat (3) tick();
        pulse_ack();
        chk("t4_clear", 32'(reset_ack), 32'd0);
        repeat (6) tick();
        chk("t4_resequenced", 32'(domain_aresetn), 32'hF);

        // 5: heartbeat pattern 0,0,0,1,1.
        pat = 5'b11000;
        do_reset(1);
        chk("t5_alive_0", 32'(alive_signal), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t5_alive", 32'(alive_signal), 32'(pat[k % 5]));
        end

        // 6: reset mid-DELAY, then mid-fault.
        domain_delay = {8'd10, 8'd10, 8'd10, 8'd10};
        cfg_int_trig_en = 1'b1;
        do_reset(1);
        repeat (4) tick();
        do_reset(1);
        chk("t6_delay_rst", {domain_aresetn, master_trigger, alive_signal, reset_ack}, 32'd0);
        chk("t6_delay_sts", sts, 32'd0);
        instant_reset_in = 1'b1;
        repeat (6) tick();
        chk("t6_fault_set", 32'(reset_ack), 32'd1);
        instant_reset_in = 1'b0;
        do_reset(1);
        chk("t6_fault_rst", {domain_aresetn, master_trigger, alive_signal, reset_ack}, 32'd0);
        chk("t6_fault_sts", sts, 32'd0);

        // Randomized phase.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_mode        = 1'($urandom);
                cfg_trig_sel    = 1'($urandom);
                cfg_int_trig_en = 1'($urandom);
                cfg_watchdog_en = 1'($urandom);
                cfg_instant_en  = 1'($urandom);
                domain_mask     = ND'($urandom);
            end
            if ($urandom_range(0, 31) == 0) begin
                for (int i = 0; i < ND; i++) domain_delay[i*DW +: DW] = DW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 7) == 0) ext_trigger = ~ext_trigger;
            if ($urandom_range(0, 2) == 0) watchdog_in = ~watchdog_in;
            if ($urandom_range(0, 19) == 0) instant_reset_in = ~instant_reset_in;
            cfg_ack_clear    = ($urandom_range(0, 5) == 0);
            peripheral_reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        peripheral_reset = 1'b0;
        cfg_ack_clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
